// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake bundle for bin_to_bcd_seq.
// master drives start/bin; slave returns busy/done/bcd.
interface bin_to_bcd_seq_if #(
  parameter int W      = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, bin,
    input  busy, done, bcd
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define LEADING_ZERO_BLANK_EN to show leading zero digits as 4'hF.
module bin_to_bcd_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input logic              clk,
  input logic              rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic            done;
  logic [BW-1:0]   bcd;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   shifted;

  // Leading digits above the top non-zero one become 4'hF;
  // digit 0 always shows so a zero value reads as "0".
  function automatic logic [BW-1:0] blank(
    input logic [BW-1:0] v
  );
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
`endif
    blank = v;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && v[4*i +: 4] == 4'd0)
        blank[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
`endif
  endfunction

  // Add-3 on every digit >= 5 (no inter-digit carry), then shift.
  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[W + 4*i +: 4] >= 4'd5)
        adj[W + 4*i +: 4] = sr[W + 4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  // Control FSM with registered busy/done/bcd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= blank('0);
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sr    <= {{BW{1'b0}}, bus.bin};
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= shifted;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd   <= blank(shifted[SW-1:W]);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.bcd  = bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq (W=8, DIGITS=3).
// Build with +define+LEADING_ZERO_BLANK_EN to check the blanking build.
module tb_bin_to_bcd_seq;

  localparam int W      = 8;
  localparam int DIGITS = 3;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [11:0] RST_BCD = 12'hFF0;
`else
  localparam logic [11:0] RST_BCD = 12'h000;
`endif

  logic clk;
  logic rst;

  bin_to_bcd_seq_if #(.W(W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  int done_count = 0;
  logic [11:0] q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, then optional blanking.
  function automatic logic [11:0] model(input int v);
    logic [11:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (r[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (r[7:4] == 4'd0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Every done pulse pops one expectation.
  always begin
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) begin
      done_count++;
      if (q.size() == 0)
        check("spurious_done", 1, 0);
      else
        check("bcd", {20'd0, bus.bcd}, {20'd0, q.pop_front()});
    end
  end

  task automatic wait_done(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) check("done_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic convert(input int v);
    int n;
    @(negedge clk);
    bus.bin   = W'(v);
    bus.start = 1'b1;
    q.push_back(model(v));
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, W);
    check("done_rise", {31'd0, bus.done}, 1);
    @(negedge clk);
    check("done_fall", {31'd0, bus.done}, 0);
  endtask

  initial begin
    int c1;
    int c2;
    int d0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_bcd", {20'd0, bus.bcd}, {20'd0, RST_BCD});
    rst = 1'b0;

    convert(255);
    convert(0);
    convert(7);
    convert(105);

    // start during SHIFT is ignored; bin wiggles freely
    @(negedge clk);
    bus.bin = 8'd99; bus.start = 1'b1;
    q.push_back(model(99));
    d0 = done_count;
    @(negedge clk);
    bus.start = 1'b0; bus.bin = 8'd17;
    @(negedge clk);
    bus.bin = 8'd33;
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 8'd200;
    @(negedge clk);
    bus.start = 1'b0; bus.bin = 8'd250;
    check("hold_bcd", {20'd0, bus.bcd}, {20'd0, model(105)});
    check("busy_mid", {31'd0, bus.busy}, 1);
    @(negedge clk);
    bus.bin = 8'd3;
    wait_done(c1);
    repeat (12) @(negedge clk);
    check("single_done", done_count - d0, 1);

    // start held high: back-to-back conversions
    @(negedge clk);
    bus.bin = 8'd128; bus.start = 1'b1;
    q.push_back(model(128));
    q.push_back(model(64));
    @(negedge clk);
    bus.bin = 8'd64;
    wait_done(c1);
    wait_done(c2);
    bus.start = 1'b0;
    check("b2b_gap", c2 - c1, 9);
    repeat (3) @(negedge clk);

    // reset aborts an in-flight conversion
    @(negedge clk);
    bus.bin = 8'd200; bus.start = 1'b1;
    q.push_back(model(200));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    d0 = done_count;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_done", {31'd0, bus.done}, 0);
    check("abort_bcd", {20'd0, bus.bcd}, {20'd0, RST_BCD});
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_count - d0, 0);
    convert(200);

    for (int v = 0; v < 256; v++) convert(v);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the per-digit seven-segment decoders. Each 4-bit slice of bcd drives one decoder input.
- The decoders blank any code >= 10. This block uses that for optional leading-zero blanking.
- Start/busy/done handshake. One bit is processed per clock, so latency is fixed at W cycles.

Parameters:
- W, 8, width of the binary input. Legal range 1..16.
- DIGITS, 3, number of BCD output digits. Configuration must satisfy 10^DIGITS > 2^W - 1; other configurations are unsupported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  W  unsigned binary value; sampled only on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new bcd result is valid.
- bcd  output  4*DIGITS  registered result; digit i occupies bits [4i+3:4i], digit 0 is least significant.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, bcd=all zeros, state=IDLE, internal scratch=0.
- Reset while in SHIFT: conversion is aborted. No done pulse is produced and bcd returns to its reset value.
- State machine, two states:
  - IDLE: busy=0.
    - On an edge with start=1: load shift register {4*DIGITS zeros, bin}, load bit counter = W, go to SHIFT.
    - On any other edge: stay in IDLE.
  - SHIFT: busy=1.
    - Each edge, every 4-bit digit field of the scratch register that is >= 5 has 3 added, using 4-bit arithmetic with no carry between digits.
    - After the adjust, the whole scratch register {digits, binary} shifts left by 1 and the counter decrements.
    - On the edge where the counter goes 1->0: the final adjusted-and-shifted digit field is loaded into bcd, done=1 for exactly the next cycle, and state returns to IDLE.
- Latency: the start-accepting edge is edge 0. busy is high after edges 0..W-1, exactly W cycles. bcd updates and done rises after edge W.
- Scratch register width: 4*DIGITS+W. Counter width: enough to hold W.
- done is cleared on the edge following its assertion, unconditionally.
- start while busy=1: ignored. No queuing, and the in-flight conversion is unaffected.
- start in the cycle where done=1: accepted, because the state is IDLE. busy rises on the next edge.
- bin changing during SHIFT: no effect, since bin is latched at acceptance.
- bcd holds the previous result for the whole of SHIFT and changes only on the done edge or on reset.
- bin=0: bcd=all zeros. bin=2^W-1: correct maximum value, no overflow given the parameter constraint.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When bcd is loaded, every digit above the most significant non-zero digit is replaced by 4'hF; downstream decoders blank it.
  - Digit 0 is never blanked, so value 0 displays as a single "0".
  - Reset value of bcd is digit0=0 with all higher digits = 4'hF.
- Undefined:
  - Leading digits are plain 4'h0.
  - Reset value of bcd is all zeros.
  - No blanking logic is synthesised.
- Handshake and latency are identical in both builds.

Test Plan (W=8, DIGITS=3):
- Reset, then bin=255 with start pulsed for 1 cycle -> busy high for 8 cycles; done high on the 8th edge after acceptance for 1 cycle; bcd=12'h255.
- bin=0, start -> bcd=12'h000 (macro off) or 12'hFF0 (macro on). Then bin=7 -> 12'h007 or 12'hFF7. Then bin=105 -> 12'h105 in both builds.
- Start with bin=99; pulse start again at cycle 3 with bin=200 and change bin every cycle -> single done; bcd=12'h099 (or 12'hF99); second start ignored.
- Back-to-back: start held high continuously with bin=128, then 64 -> done pulses 9 cycles apart; results 12'h128 then 12'h064 (macro on: 12'hF64).
- Assert rst at cycle 4 of a conversion of bin=200 -> next cycle busy=0, done=0, bcd at reset value; no done follows. A later start with bin=200 yields 12'h200.
- Exhaustive sweep of bin 0..255 against a reference model -> every result matches, each digit <= 9 or (macro on) 4'hF only in leading positions.
